// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared FPU definitions: compare-mode encoding and default field widths.
// -----------------------------------------------------------------------------
package fpu_pkg;

  typedef enum logic [1:0] {
    FLE = 2'b00,
    FLT = 2'b01,
    FEQ = 2'b10,
    RSV = 2'b11
  } fcmp_op_t;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

endpackage

// File: rtl/fcmp_classify.sv
// -----------------------------------------------------------------------------
// fcmp_classify
// Purely combinational classification of one floating-point operand.
//
// Ports:
//   a      in  1+EXP_W+MAN_W  operand {sign, exponent, mantissa}
//   isnan  out 1              exponent all ones, mantissa non-zero
//   issnan out 1              NaN whose mantissa MSB (quiet bit) is clear
//   iszero out 1              exponent and mantissa both zero (either sign)
// -----------------------------------------------------------------------------
module fcmp_classify
  import fpu_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic [EXP_W+MAN_W:0] a,
  output logic                 isnan,
  output logic                 issnan,
  output logic                 iszero
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             exp_ones;

  assign exp_f    = a[EXP_W+MAN_W-1:MAN_W];
  assign man_f    = a[MAN_W-1:0];
  assign exp_ones = &exp_f;

  assign isnan  = exp_ones && (|man_f);
  assign issnan = isnan && !man_f[MAN_W-1];
  assign iszero = !(|exp_f) && !(|man_f);

endmodule

// File: rtl/fcmp_pipe.sv
// -----------------------------------------------------------------------------
// fcmp_pipe
// Two-stage pipelined floating-point comparator (FLE / FLT / FEQ) with
// signed-zero and NaN handling, valid/ready backpressure and a pass-through tag.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operation handshake (accept on in_valid && in_ready)
//   x1, x2            operands, W = 1 + EXP_W + MAN_W bits
//   op                compare mode (00 FLE, 01 FLT, 10 FEQ, 11 reserved)
//   tag_in            opaque tag carried with the operation
//   out_valid         result valid (S2 valid bit)
//   out_ready         consumer takes result on out_valid && out_ready
//   y                 compare result
//   tag_out           tag of the operation in S2
//   invalid           invalid-operation flag
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; a producer holding valid keeps its payload stable until it is taken,
// and ready may depend combinationally on the downstream ready (no skid
// buffer), so in_ready follows out_ready within the same cycle.
// -----------------------------------------------------------------------------
module fcmp_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int TAG_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] x1,
  input  logic [EXP_W+MAN_W:0] x2,
  input  logic [1:0]           op,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 y,
  output logic [TAG_W-1:0]     tag_out,
  output logic                 invalid
);

  localparam int W = 1 + EXP_W + MAN_W;

  // Stage-0 classification of the raw operands.
  logic nan1, nan2, snan1, snan2, zero1, zero2;

  fcmp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls1 (
    .a      (x1),
    .isnan  (nan1),
    .issnan (snan1),
    .iszero (zero1)
  );

  fcmp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls2 (
    .a      (x2),
    .isnan  (nan2),
    .issnan (snan2),
    .iszero (zero2)
  );

  // Unsigned compare of {exponent, mantissa}: IEEE encoding makes magnitude
  // order identical to integer order of these bits.
  logic mag_lt, mag_eq;
  assign mag_lt = x1[W-2:0] <  x2[W-2:0];
  assign mag_eq = x1[W-2:0] == x2[W-2:0];

  // S1 registers
  logic             s1_valid;
  logic             s1_nan1, s1_nan2, s1_snan1, s1_snan2, s1_bothzero;
  logic             s1_sign1, s1_sign2;
  logic             s1_lt, s1_eq;
  fcmp_op_t         s1_op;
  logic [TAG_W-1:0] s1_tag;

  // S2 valid; the S2 payload registers are the outputs y/invalid/tag_out.
  logic s2_valid;

  logic s2_free, s1_adv, accept;

  assign s2_free   = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_free;
  assign in_ready  = !s1_valid || s2_free;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  // Result computation from the S1 snapshot.
  logic any_nan, any_snan, ord_eq, ord_lt;
  logic res_y, res_inv;

  always_comb begin
    any_nan  = s1_nan1 || s1_nan2;
    any_snan = s1_snan1 || s1_snan2;
    // +0 and -0 are equal; otherwise equality needs identical bit patterns.
    ord_eq   = s1_bothzero || ((s1_sign1 == s1_sign2) && s1_eq);

    ord_lt = 1'b0;
    if (s1_bothzero) begin
      ord_lt = 1'b0;
    end else if (s1_sign1 != s1_sign2) begin
      ord_lt = s1_sign1;
    end else if (!s1_sign1) begin
      ord_lt = s1_lt;
    end else begin
      // Both negative: the larger magnitude is the smaller value.
      ord_lt = !s1_lt && !s1_eq;
    end

    res_y   = 1'b0;
    res_inv = 1'b0;
    unique case (s1_op)
      FLE: begin
        res_y   = !any_nan && (ord_lt || ord_eq);
        res_inv = any_nan;
      end
      FLT: begin
        res_y   = !any_nan && ord_lt;
        res_inv = any_nan;
      end
      FEQ: begin
        res_y   = !any_nan && ord_eq;
        res_inv = any_snan;
      end
      RSV: begin
        res_y   = 1'b0;
        res_inv = 1'b0;
      end
      default: begin
        res_y   = 1'b0;
        res_inv = 1'b0;
      end
    endcase
  end

  // Valid bits and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      y        <= 1'b0;
      invalid  <= 1'b0;
      tag_out  <= '0;
    end else begin
      // A new accept overwrites S1 even while S1 advances: no bubble.
      if (accept) begin
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s2_free) begin
        s2_valid <= s1_valid;
      end

      // Payload only changes when a real operation moves in, so the outputs
      // stay stable under stall.
      if (s1_adv) begin
        y       <= res_y;
        invalid <= res_inv;
        tag_out <= s1_tag;
      end
    end
  end

  // S1 datapath: loaded only on accept, qualified by s1_valid elsewhere.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_nan1     <= nan1;
      s1_nan2     <= nan2;
      s1_snan1    <= snan1;
      s1_snan2    <= snan2;
      s1_bothzero <= zero1 && zero2;
      s1_sign1    <= x1[W-1];
      s1_sign2    <= x2[W-1];
      s1_lt       <= mag_lt;
      s1_eq       <= mag_eq;
      s1_op       <= fcmp_op_t'(op);
      s1_tag      <= tag_in;
    end
  end

endmodule

// File: doc/fcmp_pipe.md
# fcmp_pipe

Parametrised, pipelined floating-point comparator for the FPU. It supports three compare modes (FLE, FLT, FEQ) with IEEE-style signed-zero and NaN rules. A valid/ready handshake provides backpressure, and a tag is carried alongside each result. It sits between the FPU issue logic and the integer writeback path and produces a 1-bit result per operation.

## Interface
- `EXP_W`, default 8: exponent field width.
- `MAN_W`, default 23: mantissa field width. Operand width `W = 1 + EXP_W + MAN_W`.
- `TAG_W`, default 5: width of the opaque tag (destination register id).
- `clk`  in  1: clock.
- `rst`  in  1: reset. Synchronous, active-high.
- `in_valid`  in  1: operation offered.
- `in_ready`  out  1: operation accepted when `in_valid && in_ready`.
- `x1`  in  W: first operand.
- `x2`  in  W: second operand.
- `op`  in  2: compare mode. 00 FLE (x1 ≤ x2), 01 FLT (x1 < x2), 10 FEQ (x1 == x2), 11 reserved.
- `tag_in`  in  TAG_W: tag, passed through unchanged.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer takes the result when `out_valid && out_ready`.
- `y`  out  1: compare result (1 = true).
- `tag_out`  out  TAG_W: tag of the operation.
- `invalid`  out  1: set when either operand is NaN on FLT/FLE (signalling-compare flag), or when either operand is sNaN on FEQ.

## Operation
- NaN: exponent all ones and mantissa ≠ 0. sNaN: NaN with mantissa MSB = 0.
- Zero: exponent and mantissa both 0. +0 and −0 compare equal under every mode.
- Any NaN operand forces `y = 0` in all modes.
- Ordered magnitude compare on bits [W-2:0]:
  - Signs differ, not both zero: the negative operand is smaller.
  - Both positive: smaller magnitude is smaller.
  - Both negative: larger magnitude is smaller.
- Mode results:
  - FEQ: equal bit patterns, or both zero.
  - FLT: strict less.
  - FLE: FLT or FEQ.
  - op = 11: `y = 0`, `invalid = 0`.
- Tag, `y` and `invalid` stay associated with the operation through the pipeline. Results leave in issue order.

## Timing
- Two register stages, S1 and S2, each with its own valid bit.
- S1 captures classification flags (isnan1/2, issnan1/2, bothzero), the sign pair, magnitude `lt`/`eq`, `op` and the tag.
- S2 holds the final `y`, `invalid` and tag. Outputs are driven directly from S2 registers.
- Latency: accept in cycle N → `out_valid` in cycle N+2 when there is no stall.
- Throughput: 1 operation per cycle.
- Advance rules:
  - `s2_free = !s2_valid || out_ready`
  - `s1_adv = s1_valid && s2_free`
  - `in_ready = !s1_valid || s2_free`
  - `in_ready` is combinational from `out_ready` (no skid buffer).
- Simultaneous accept and advance in the same cycle is legal. S1 is overwritten with the new operation, so there is no bubble.
- On full stall (`out_ready = 0`, both stages valid): `in_ready = 0` and all registers hold.
- S2 outputs are stable while `out_valid && !out_ready`.
- Reset: `s1_valid = s2_valid = 0`, `out_valid = 0`, `y = 0`, `invalid = 0`, `tag_out = 0`.
  - `in_ready` reads 1 in the cycle after reset deasserts.
  - Reset asserted mid-operation discards all in-flight operations. No result is emitted for them.
- Inputs are sampled only on the accept edge. Operand changes while `in_ready = 0` have no effect.

## Structure
- `fpu_pkg` holds:
  - enum `fcmp_op_t` (FLE = 2'b00, FLT = 2'b01, FEQ = 2'b10, RSV = 2'b11);
  - default constants `FP_EXP_W = 8`, `FP_MAN_W = 23`.
- One combinational sub-module, `fcmp_classify`, parametrised by `EXP_W`/`MAN_W`. Given a single operand it returns isnan, issnan and iszero. It is instantiated twice, feeding the S1 register.
- The magnitude compare and the result mux stay in `fcmp_pipe`.

## Test plan
- FLT, x1 = 0xBF800000 (−1.0), x2 = 0x3F800000 (1.0) → `y = 1`, `invalid = 0`, `out_valid` 2 cycles after accept. Swapped operands → `y = 0`.
- Both negative, FLT, x1 = 0xC0000000 (−2.0), x2 = 0xBF800000 (−1.0) → `y = 1`. FLE with x1 = x2 = 0xBF800000 → `y = 1`.
- Signed zero, x1 = 0x80000000, x2 = 0x00000000:
  - FEQ → 1;
  - FLT → 0;
  - FLE → 1.
- NaN handling:
  - FLE, x1 = 0x7FC00000 (qNaN), x2 = 0x3F800000 → `y = 0`, `invalid = 1`.
  - FEQ with the same operands → `y = 0`, `invalid = 0`.
  - FEQ, x1 = 0x7FA00000 (sNaN) → `y = 0`, `invalid = 1`.
- Backpressure: issue 4 ops with tags 1–4 every cycle while `out_ready = 0` for 3 cycles → `in_ready` falls after 2 accepts. After `out_ready` rises, tags come out 1,2,3,4 in order, each with the correct `y`, no loss or duplication.
- Reset with S1 and S2 valid → next cycle `out_valid = 0`, `y = 0`, `tag_out = 0`, `in_ready = 1`. No stale result appears afterwards.
